clock_time_ctrl: RTL and testbench

Sequencing controller for the seconds/minutes/hours `counter` chain of the clock. It divides the system clock into a one-second tick and routes carries between stages, producing each counter's `work_en`. A three-button setup FSM adjusts hours and minutes through the counters' `setup_imp`/`setup_data` load path.

---
 rtl/clock_time_ctrl_if.sv | 41 ++++
 rtl/clock_time_ctrl.sv | 154 +++++++++++++++
 tb/tb_clock_time_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/clock_time_ctrl_if.sv
// rtl/clock_time_ctrl_if.sv - button, counter-feedback and counter-control signals of the clock sequencer
interface clock_time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [7:0] sec_val;
    logic [7:0] min_val;
    logic [7:0] hour_val;
    logic       sec_carry;
    logic       min_carry;
    logic       sec_work_en;
    logic       min_work_en;
    logic       hour_work_en;
    logic       up_down;
    logic       sec_setup;
    logic       min_setup;
    logic       hour_setup;
    logic [7:0] setup_data;
    logic [1:0] mode;
    logic       blink;

    // Controller side
    modport master (
        input  btn_mode, btn_inc, btn_dec,
        input  sec_val, min_val, hour_val,
        input  sec_carry, min_carry,
        output sec_work_en, min_work_en, hour_work_en, up_down,
        output sec_setup, min_setup, hour_setup, setup_data,
        output mode, blink
    );

    // Buttons and counter chain side
    modport slave (
        output btn_mode, btn_inc, btn_dec,
        output sec_val, min_val, hour_val,
        output sec_carry, min_carry,
        input  sec_work_en, min_work_en, hour_work_en, up_down,
        input  sec_setup, min_setup, hour_setup, setup_data,
        input  mode, blink
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - one-second prescaler, carry routing and hour/minute setup FSM; optional blink via CLOCK_CTRL_BLINK_EN
module clock_time_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 59,
    parameter int HOUR_MAX = 23
) (
    input  logic              clock,
    input  logic              reset,
    clock_time_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_BAD      = 2'b11
    } state_t;

    localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PCNT_TERM = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   PCNT_HALF = PW'(TICK_DIV / 2 - 1);
    localparam logic [7:0]      SEC_ZERO  = 8'(SEC_MAX - SEC_MAX);

    state_t        r_state;
    state_t        w_next_state;
    logic [PW-1:0] r_pcnt;
    logic          r_sec_pulse;
    logic          r_sec_setup;
    logic          r_min_setup;
    logic          r_hour_setup;
    logic [7:0]    r_setup_data;

    logic          w_tick;
    logic          w_guard;
    logic          w_step;
    logic          w_sec_ld;
    logic          w_min_ld;
    logic          w_hour_ld;
    logic [7:0]    w_ld_data;
    logic          w_pcnt_clr;
    logic          w_run;

    assign w_tick  = (r_pcnt == PCNT_TERM);
    assign w_run   = (r_state == ST_RUN);
    // Counter data lags a load by one cycle, so a step right after any strobe would use a stale value
    assign w_guard = r_sec_setup | r_min_setup | r_hour_setup;
    assign w_step  = (bus.btn_inc ^ bus.btn_dec) & ~w_guard;

    // Next state and load-strobe decode; mode button has priority over inc/dec
    always_comb begin
        w_next_state = r_state;
        w_sec_ld     = 1'b0;
        w_min_ld     = 1'b0;
        w_hour_ld    = 1'b0;
        w_ld_data    = 8'd0;
        w_pcnt_clr   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (bus.btn_mode) w_next_state = ST_SET_HOUR;
            end
            ST_SET_HOUR: begin
                if (bus.btn_mode) begin
                    w_next_state = ST_SET_MIN;
                end else if (w_step) begin
                    w_hour_ld = 1'b1;
                    if (bus.btn_inc)
                        w_ld_data = (bus.hour_val == 8'(HOUR_MAX)) ? 8'd0 : bus.hour_val + 8'd1;
                    else
                        w_ld_data = (bus.hour_val == 8'd0) ? 8'(HOUR_MAX) : bus.hour_val - 8'd1;
                end
            end
            ST_SET_MIN: begin
                if (bus.btn_mode) begin
                    // Restart the current minute cleanly when resuming time
                    w_next_state = ST_RUN;
                    w_sec_ld     = 1'b1;
                    w_ld_data    = SEC_ZERO;
                    w_pcnt_clr   = 1'b1;
                end else if (w_step) begin
                    w_min_ld = 1'b1;
                    if (bus.btn_inc)
                        w_ld_data = (bus.min_val == 8'(MIN_MAX)) ? 8'd0 : bus.min_val + 8'd1;
                    else
                        w_ld_data = (bus.min_val == 8'd0) ? 8'(MIN_MAX) : bus.min_val - 8'd1;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_next_state;
    end

    // Free-running one-second prescaler, realigned when leaving setup
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                   r_pcnt <= '0;
        else if (w_pcnt_clr || w_tick) r_pcnt <= '0;
        else                          r_pcnt <= r_pcnt + 1'b1;
    end

    // Seconds enable pulse, one cycle after the terminal prescaler count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_sec_pulse <= 1'b0;
        else        r_sec_pulse <= w_tick & w_run;
    end

    // Registered load strobes and shared load value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sec_setup  <= 1'b0;
            r_min_setup  <= 1'b0;
            r_hour_setup <= 1'b0;
            r_setup_data <= 8'd0;
        end else begin
            r_sec_setup  <= w_sec_ld;
            r_min_setup  <= w_min_ld;
            r_hour_setup <= w_hour_ld;
            r_setup_data <= w_ld_data;
        end
    end

`ifdef CLOCK_CTRL_BLINK_EN
    logic r_blink;

    // Blink at 1 Hz while setting; restarts dark on every state change
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_blink <= 1'b0;
        else if ((w_next_state == ST_RUN) || (w_next_state != r_state))
            r_blink <= 1'b0;
        else if ((r_pcnt == PCNT_HALF) || w_tick)
            r_blink <= ~r_blink;
    end

    assign bus.blink = r_blink;
`else
    assign bus.blink = 1'b0;
`endif

    assign bus.sec_work_en  = r_sec_pulse & w_run;
    assign bus.min_work_en  = bus.sec_carry & w_run;
    assign bus.hour_work_en = bus.min_carry & w_run;
    assign bus.up_down      = 1'b1;
    assign bus.sec_setup    = r_sec_setup;
    assign bus.min_setup    = r_min_setup;
    assign bus.hour_setup   = r_hour_setup;
    assign bus.setup_data   = r_setup_data;
    assign bus.mode         = r_state;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - directed vector bench for clock_time_ctrl
module tb_clock_time_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   failures;

    clock_time_ctrl_if bus ();

    clock_time_ctrl #(
        .TICK_DIV (4),
        .SEC_MAX  (59),
        .MIN_MAX  (59),
        .HOUR_MAX (23)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       m, i, d;
        logic [7:0] hv, mv;
        logic       sc, mc;
        logic [1:0] e_mode;
        logic       e_hs, e_ms, e_ss;
        logic [7:0] e_data;
        logic       e_mwe, e_hwe;
    } vec_t;

    vec_t vt [23];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.btn_mode  = 1'b0;
        bus.btn_inc   = 1'b0;
        bus.btn_dec   = 1'b0;
        bus.sec_carry = 1'b0;
        bus.min_carry = 1'b0;
    endtask

    initial begin
        logic [5:0] blink_exp;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        drive_idle();
        bus.sec_val  = 8'd0;
        bus.min_val  = 8'd0;
        bus.hour_val = 8'd0;

        //            m  i  d  hv     mv     sc mc  mode hs ms ss data   mwe hwe
        vt[0]  = '{1'b0,1'b0,1'b0,8'd0, 8'd0, 1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,8'd0, 1'b1,1'b0};
        vt[1]  = '{1'b0,1'b0,1'b0,8'd0, 8'd0, 1'b0,1'b1,2'd0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b1};
        vt[2]  = '{1'b0,1'b1,1'b0,8'd5, 8'd0, 1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[3]  = '{1'b1,1'b0,1'b0,8'd5, 8'd0, 1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[4]  = '{1'b0,1'b1,1'b0,8'd23,8'd0, 1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[5]  = '{1'b0,1'b0,1'b0,8'd0, 8'd0, 1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[6]  = '{1'b0,1'b0,1'b1,8'd0, 8'd0, 1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,8'd23,1'b0,1'b0};
        vt[7]  = '{1'b0,1'b0,1'b0,8'd23,8'd0, 1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[8]  = '{1'b0,1'b0,1'b1,8'd5, 8'd0, 1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,8'd4, 1'b0,1'b0};
        vt[9]  = '{1'b0,1'b0,1'b0,8'd4, 8'd0, 1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[10] = '{1'b0,1'b1,1'b0,8'd5, 8'd0, 1'b0,1'b0,2'd1,1'b1,1'b0,1'b0,8'd6, 1'b0,1'b0};
        vt[11] = '{1'b0,1'b0,1'b0,8'd6, 8'd0, 1'b0,1'b0,2'd1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[12] = '{1'b0,1'b0,1'b0,8'd6, 8'd0, 1'b1,1'b1,2'd1,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[13] = '{1'b1,1'b0,1'b1,8'd6, 8'd0, 1'b0,1'b0,2'd2,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[14] = '{1'b0,1'b1,1'b0,8'd6, 8'd10,1'b0,1'b0,2'd2,1'b0,1'b1,1'b0,8'd11,1'b0,1'b0};
        vt[15] = '{1'b0,1'b1,1'b0,8'd6, 8'd10,1'b0,1'b0,2'd2,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[16] = '{1'b0,1'b1,1'b1,8'd6, 8'd10,1'b0,1'b0,2'd2,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[17] = '{1'b0,1'b0,1'b1,8'd6, 8'd0, 1'b0,1'b0,2'd2,1'b0,1'b1,1'b0,8'd59,1'b0,1'b0};
        vt[18] = '{1'b0,1'b0,1'b0,8'd6, 8'd59,1'b0,1'b0,2'd2,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[19] = '{1'b0,1'b1,1'b0,8'd6, 8'd59,1'b0,1'b0,2'd2,1'b0,1'b1,1'b0,8'd0, 1'b0,1'b0};
        vt[20] = '{1'b0,1'b0,1'b0,8'd6, 8'd0, 1'b0,1'b0,2'd2,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[21] = '{1'b0,1'b0,1'b0,8'd6, 8'd0, 1'b1,1'b1,2'd2,1'b0,1'b0,1'b0,8'd0, 1'b0,1'b0};
        vt[22] = '{1'b1,1'b1,1'b0,8'd6, 8'd10,1'b0,1'b0,2'd0,1'b0,1'b0,1'b1,8'd0, 1'b0,1'b0};

        // Reset state
        #3;
        chk("rst_mode",    32'(bus.mode), 32'd0);
        chk("rst_up_down", 32'(bus.up_down), 32'd1);
        chk("rst_strobes", 32'({bus.sec_setup, bus.min_setup, bus.hour_setup}), 32'd0);
        chk("rst_data",    32'(bus.setup_data), 32'd0);
        chk("rst_work_en", 32'({bus.sec_work_en, bus.min_work_en, bus.hour_work_en}), 32'd0);
        chk("rst_blink",   32'(bus.blink), 32'd0);

        // Free run: pulse visible after edges 4, 8, 12, ...
        @(negedge clock);
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            chk("run_sec_work_en", 32'(bus.sec_work_en), 32'((k % 4) == 0));
            chk("run_mode", 32'(bus.mode), 32'd0);
            chk("run_strobes", 32'({bus.sec_setup, bus.min_setup, bus.hour_setup}), 32'd0);
        end

        // Vector table
        for (int n = 0; n < 23; n++) begin
            @(negedge clock);
            bus.btn_mode  = vt[n].m;
            bus.btn_inc   = vt[n].i;
            bus.btn_dec   = vt[n].d;
            bus.hour_val  = vt[n].hv;
            bus.min_val   = vt[n].mv;
            bus.sec_val   = 8'd59;
            bus.sec_carry = vt[n].sc;
            bus.min_carry = vt[n].mc;
            @(posedge clock);
            #1;
            chk($sformatf("v%0d_mode", n),       32'(bus.mode),         32'(vt[n].e_mode));
            chk($sformatf("v%0d_hour_setup", n), 32'(bus.hour_setup),   32'(vt[n].e_hs));
            chk($sformatf("v%0d_min_setup", n),  32'(bus.min_setup),    32'(vt[n].e_ms));
            chk($sformatf("v%0d_sec_setup", n),  32'(bus.sec_setup),    32'(vt[n].e_ss));
            chk($sformatf("v%0d_setup_data", n), 32'(bus.setup_data),   32'(vt[n].e_data));
            chk($sformatf("v%0d_min_work_en", n),32'(bus.min_work_en),  32'(vt[n].e_mwe));
            chk($sformatf("v%0d_hour_work_en", n),32'(bus.hour_work_en),32'(vt[n].e_hwe));
            if (vt[n].e_mode != 2'd0)
                chk($sformatf("v%0d_sec_frozen", n), 32'(bus.sec_work_en), 32'd0);
        end

        // After leaving SET_MIN the prescaler restarts: pulse after the fourth edge
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            drive_idle();
            @(posedge clock);
            #1;
            chk($sformatf("resume_sec_work_en_%0d", k), 32'(bus.sec_work_en), 32'(k == 4));
            chk($sformatf("resume_strobes_%0d", k),
                32'({bus.sec_setup, bus.min_setup, bus.hour_setup}), 32'd0);
        end

        // Enter SET_HOUR and load, then reset mid-cycle while the strobe is high
        @(negedge clock);
        bus.btn_mode = 1'b1;
        @(negedge clock);
        drive_idle();
        bus.btn_inc  = 1'b1;
        bus.hour_val = 8'd7;
        @(posedge clock);
        #1;
        chk("pre_rst_hour_setup", 32'(bus.hour_setup), 32'd1);
        chk("pre_rst_data", 32'(bus.setup_data), 32'd8);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_mode", 32'(bus.mode), 32'd0);
        chk("async_rst_strobe", 32'({bus.sec_setup, bus.min_setup, bus.hour_setup}), 32'd0);
        chk("async_rst_data", 32'(bus.setup_data), 32'd0);
        chk("async_rst_up_down", 32'(bus.up_down), 32'd1);

        // Release with btn_mode pending so pcnt phase is known on SET_HOUR entry
`ifdef CLOCK_CTRL_BLINK_EN
        blink_exp = 6'b100110;
`else
        blink_exp = 6'b000000;
`endif
        @(negedge clock);
        drive_idle();
        reset = 1'b1;
        bus.btn_mode = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("blink_%0d", k), 32'(bus.blink), 32'(blink_exp[k-1]));
            chk($sformatf("blink_mode_%0d", k), 32'(bus.mode), 32'd1);
            @(negedge clock);
            drive_idle();
        end
        reset = 1'b0;
        #1;
        chk("final_rst_blink", 32'(bus.blink), 32'd0);
        chk("final_rst_mode", 32'(bus.mode), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
